panel_bus_master: RTL
=====================

Name: panel_bus_master

Overview:
- Front-panel bus initiator: performs EXAMINE / DEPOSIT memory cycles on the 8080-style system bus in place of the CPU.
- Uses the same signal set the CPU drives: addr, odata, sync, rd, wr_n, all paced by the shared half-rate ce.
- Requests the bus with hold/hlda, emits a status byte during sync so the existing sysctl latch decodes a memory cycle, runs one access, then returns the bus.
- The top-level mux selects panel signals when bus_own=1.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 8, bus data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ce  in  1  bus phase enable, the same toggling ce the CPU uses
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
- cmd_op  in  2  00 EXAMINE, 01 EXAMINE_NEXT, 10 DEPOSIT, 11 DEPOSIT_NEXT
- cmd_addr  in  ADDR_WIDTH  target address (ignored for *_NEXT)
- cmd_data  in  DATA_WIDTH  deposit data
- rsp_valid  out  1  one-clk completion pulse
- rsp_data  out  DATA_WIDTH  read data (EXAMINE) or written data (DEPOSIT)
- rsp_err  out  1  valid with rsp_valid, 1 = aborted by hlda loss
- cur_addr  out  ADDR_WIDTH  panel address register (LED display)
- hold  out  1  bus request to CPU
- hlda  in  1  CPU hold acknowledge
- bus_own  out  1  panel currently drives bus
- addr  out  ADDR_WIDTH  bus address
- odata  out  DATA_WIDTH  status byte during sync, write data otherwise
- sync  out  1  status phase strobe
- rd  out  1  read strobe, active high
- wr_n  out  1  write strobe, active low
- idata  in  DATA_WIDTH  read data from decoder mux

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, cmd_ready=1, hold=0, bus_own=0, sync=0, rd=0, wr_n=1, addr=0, odata=0, rsp_valid=0, rsp_err=0, rsp_data=0, cur_addr=0. Reset mid-operation aborts at once, with no response pulse.
- While bus_own=0: addr=0, odata=0, sync=0, rd=0, wr_n=1.
- Accept: on cmd_valid&cmd_ready, latch op and data.
  - cur_addr <= cmd_addr for EXAMINE/DEPOSIT.
  - cur_addr <= cur_addr+1 for *_NEXT; wraps 0xFFFF->0x0000 (modulo 2^ADDR_WIDTH).
  - cmd_ready drops the next cycle. cmd_valid while busy is ignored.
- FSM (transitions marked [ce] occur only on clk edges with ce=1):
  - IDLE -> REQ on accept; hold=1.
  - REQ -> SYNC when hlda=1, sampled on any clk; hold stays 1 until RELEASE.
  - SYNC -> ACCESS [ce]. In SYNC: bus_own=1, sync=1, addr=cur_addr, odata=status (0x82 for read: MEMR|WO_n; 0x00 for write).
  - ACCESS -> DONE [ce]. In ACCESS: sync=0, addr=cur_addr.
    - Read: rd=1 for the whole state. idata is captured into rsp_data on the exit edge (synchronous memory data is valid one clk after rd).
    - Write: wr_n=0 and odata=latched data for the whole state; rsp_data <= latched data.
  - DONE: one clk, rsp_valid=1, rsp_err=0, bus idle values, bus_own=0 -> RELEASE.
  - RELEASE: hold=0; -> IDLE when hlda=0; cmd_ready=1 in IDLE.
- hlda dropping in SYNC or ACCESS: bus_own=0 and strobes idle on the next clk, rsp_valid=1 with rsp_err=1, then RELEASE. A DEPOSIT aborted this way may be incomplete; rsp_data is unchanged. cur_addr keeps the already-updated value.
- Latency: from hlda=1 to rsp_valid is at most 4 ce periods plus 1 clk.
- Strobes are mutually exclusive: rd and ~wr_n are never both 1, and sync is never 1 together with either strobe.

Test Plan:
- DEPOSIT addr=0x0100 data=0x3E, hlda tied to hold with 1-clk delay -> one SYNC phase with odata=0x00, then wr_n=0 for 2 clk at addr 0x0100; rsp_valid=1, rsp_data=0x3E, rsp_err=0; main RAM[0x100]=0x3E.
- EXAMINE 0x0100 after previous -> SYNC odata=0x82, rd=1 for 2 clk; rsp_data=0x3E.
- DEPOSIT_NEXT 0x11, then EXAMINE_NEXT -> cur_addr 0x0101 with RAM[0x101]=0x11, then cur_addr 0x0102 with rsp_data = preloaded RAM[0x102].
- EXAMINE 0xFFFF then EXAMINE_NEXT -> cur_addr wraps to 0x0000; reads RAM[0x0000].
- Hold hlda=0 for 20 clk after request -> no strobes, bus_own=0, cmd_ready=0. Raise hlda, then drop it during ACCESS -> rsp_valid with rsp_err=1, hold=0, return to IDLE after hlda=0.
- reset=0 asserted during ACCESS of a DEPOSIT -> next clk: hold=0, wr_n=1, cur_addr=0, cmd_ready=1, no rsp_valid.

Source files
------------

// File: rtl/panel_bus_master.sv
// Front-panel bus initiator: takes the bus from the CPU via hold/hlda and runs one
// EXAMINE or DEPOSIT memory cycle with CPU-compatible sync/status, rd and wr_n timing.
module panel_bus_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] cur_addr,
    output logic                  hold,
    input  logic                  hlda,
    output logic                  bus_own,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  sync,
    output logic                  rd,
    output logic                  wr_n,
    input  logic [DATA_WIDTH-1:0] idata
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SYNC, S_ACCESS, S_DONE, S_ABORT, S_RELEASE
    } state_t;

    // MEMR | WO_n: the sysctl latch decodes this as a memory read cycle
    localparam logic [DATA_WIDTH-1:0] STATUS_RD = DATA_WIDTH'(8'h82);
    localparam logic [DATA_WIDTH-1:0] STATUS_WR = '0;

    state_t                state, state_nxt;
    logic                  op_wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_wr    <= 1'b0;
            wdata    <= '0;
            cur_addr <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_wr    <= cmd_op[1];
                wdata    <= cmd_data;
                cur_addr <= cmd_op[0] ? cur_addr + ADDR_WIDTH'(1) : cmd_addr;
            end
            // Only a completed access updates rsp_data; an aborted one leaves it alone
            if (state == S_ACCESS && ce && hlda)
                rsp_data <= op_wr ? wdata : idata;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        hold      = 1'b0;
        bus_own   = 1'b0;
        addr      = '0;
        odata     = '0;
        sync      = 1'b0;
        rd        = 1'b0;
        wr_n      = 1'b1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_REQ;
            end
            S_REQ: begin
                hold = 1'b1;
                if (hlda) state_nxt = S_SYNC;
            end
            S_SYNC: begin
                hold    = 1'b1;
                bus_own = 1'b1;
                sync    = 1'b1;
                addr    = cur_addr;
                odata   = op_wr ? STATUS_WR : STATUS_RD;
                if (!hlda)   state_nxt = S_ABORT;
                else if (ce) state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                hold    = 1'b1;
                bus_own = 1'b1;
                addr    = cur_addr;
                if (op_wr) begin
                    wr_n  = 1'b0;
                    odata = wdata;
                end else begin
                    rd = 1'b1;
                end
                if (!hlda)   state_nxt = S_ABORT;
                else if (ce) state_nxt = S_DONE;
            end
            S_DONE: begin
                hold      = 1'b1;
                rsp_valid = 1'b1;
                state_nxt = S_RELEASE;
            end
            S_ABORT: begin
                hold      = 1'b1;
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!hlda) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
